// File: rtl/cg_merge_pkg.sv
// Shared types and helpers for the clock-enable merging register bank.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cg_merge_pkg;

  // Per-group idle behaviour.
  typedef enum logic {
    HOLD_ON_IDLE = 1'b0,
    COPY_ON_IDLE = 1'b1
  } grp_mode_e;

  // Copy source for group g: its upper neighbour, wrapping at the top.
  function automatic int src_idx(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/cg_merge_group.sv
// One register group: raw enable, next value and gated storage.
// Latency: one cycle from inputs to val.
// Backpressure: none; the group captures whenever its effective enable is high.
// Ports: clk/rst; valid/last strobes; mode; merge/shared_en (bank-wide enable);
//        in_grp (load data); src_val (neighbour's pre-edge value);
//        raw_en (this group's own enable); val (registered contents).
module cg_merge_group
  import cg_merge_pkg::*;
#(
  parameter int GW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          last,
  input  grp_mode_e     mode,
  input  logic          merge,
  input  logic          shared_en,
  input  logic [GW-1:0] in_grp,
  input  logic [GW-1:0] src_val,
  output logic          raw_en,
  output logic [GW-1:0] val
);

  logic          clk_en;
  logic [GW-1:0] nxt;
  logic [GW-1:0] d;

  always_comb begin
    raw_en = valid | ((mode == COPY_ON_IDLE) & ~last);
    // A HOLD group is only enabled by valid, so the copy path is never taken for it.
    nxt    = valid ? in_grp : src_val;
    clk_en = merge ? shared_en : raw_en;
    // Under the shared enable, groups that would have held recirculate their own value,
    // so contents are identical with or without merging.
    d      = raw_en ? nxt : val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val <= '0;
    end else if (clk_en) begin
      val <= d;
    end
  end

endmodule

// File: rtl/cg_merge_regbank.sv
// Register bank with per-group clock enables, optional single merged enable, and activity counters.
// Latency: one cycle from inputs to out; en_vec is combinational for the coming edge.
// Backpressure: none; loads are accepted every cycle, counters saturate instead of wrapping.
// Ports: clk/rst; valid/last; in_data; cfg_we/cfg_mode/cfg_merge; cnt_clr;
//        out (bank contents); en_vec (effective enables); en_bits/en_cycles (activity counters).
module cg_merge_regbank
  import cg_merge_pkg::*;
#(
  parameter int N_GROUPS = 4,
  parameter int GW       = 8,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic                   last,
  input  logic [N_GROUPS*GW-1:0] in_data,
  input  logic                   cfg_we,
  input  logic [N_GROUPS-1:0]    cfg_mode,
  input  logic                   cfg_merge,
  input  logic                   cnt_clr,
  output logic [N_GROUPS*GW-1:0] out,
  output logic [N_GROUPS-1:0]    en_vec,
  output logic [CNT_W-1:0]       en_bits,
  output logic [CNT_W-1:0]       en_cycles
);

  // Headroom so one increment on top of a full counter cannot overflow the sum.
  localparam int INC_W = $clog2(N_GROUPS * GW + 1);
  localparam int SUM_W = CNT_W + INC_W + 1;

  logic [N_GROUPS-1:0] mode_q;
  logic                merge_q;
  logic [N_GROUPS-1:0] raw_en;
  logic                any_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= '0;
      merge_q <= 1'b0;
    end else if (cfg_we) begin
      mode_q  <= cfg_mode;
      merge_q <= cfg_merge;
    end
  end

  assign any_en = |raw_en;
  assign en_vec = merge_q ? {N_GROUPS{any_en}} : raw_en;

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_grp
    localparam int SRC = src_idx(g, N_GROUPS);
    cg_merge_group #(.GW(GW)) u_grp (
      .clk       (clk),
      .rst       (rst),
      .valid     (valid),
      .last      (last),
      .mode      (grp_mode_e'(mode_q[g])),
      .merge     (merge_q),
      .shared_en (any_en),
      .in_grp    (in_data[g*GW +: GW]),
      .src_val   (out[SRC*GW +: GW]),
      .raw_en    (raw_en[g]),
      .val       (out[g*GW +: GW])
    );
  end

  logic [SUM_W-1:0] bits_inc;
  logic [SUM_W-1:0] bits_sum;
  logic [CNT_W:0]   cyc_sum;
  logic [CNT_W-1:0] bits_nxt;
  logic [CNT_W-1:0] cyc_nxt;

  always_comb begin
    bits_inc = '0;
    for (int g = 0; g < N_GROUPS; g++) begin
      if (en_vec[g]) bits_inc = bits_inc + SUM_W'(GW);
    end
    bits_sum = {{(SUM_W-CNT_W){1'b0}}, en_bits} + bits_inc;
    bits_nxt = (bits_sum > {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}}
                                                                    : bits_sum[CNT_W-1:0];
    cyc_sum  = {1'b0, en_cycles} + {{CNT_W{1'b0}}, |en_vec};
    cyc_nxt  = cyc_sum[CNT_W] ? {CNT_W{1'b1}} : cyc_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      en_bits   <= '0;
      en_cycles <= '0;
    end else begin
      en_bits   <= bits_nxt;
      en_cycles <= cyc_nxt;
    end
  end

endmodule

// File: tb/tb_cg_merge_regbank.sv
module tb_cg_merge_regbank;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        last;
  logic [31:0] in_data;
  logic        cfg_we;
  logic [3:0]  cfg_mode;
  logic        cfg_merge;
  logic        cnt_clr;
  logic        s_clr;

  logic [31:0] d_out;
  logic [3:0]  d_en_vec;
  logic [31:0] d_bits;
  logic [31:0] d_cycles;

  logic [31:0] s_out;
  logic [3:0]  s_en_vec;
  logic [7:0]  s_bits;
  logic [7:0]  s_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cg_merge_regbank #(.N_GROUPS(4), .GW(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .last(last), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_merge(cfg_merge), .cnt_clr(cnt_clr),
    .out(d_out), .en_vec(d_en_vec), .en_bits(d_bits), .en_cycles(d_cycles)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  cg_merge_regbank #(.N_GROUPS(4), .GW(8), .CNT_W(8)) dut_s (
    .clk(clk), .rst(rst), .valid(valid), .last(last), .in_data(in_data),
    .cfg_we(cfg_we), .cfg_mode(cfg_mode), .cfg_merge(cfg_merge), .cnt_clr(s_clr),
    .out(s_out), .en_vec(s_en_vec), .en_bits(s_bits), .en_cycles(s_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] o, input logic [31:0] b,
                           input logic [31:0] c);
    chk({tag, ".out"}, d_out, o);
    chk({tag, ".bits"}, d_bits, b);
    chk({tag, ".cycles"}, d_cycles, c);
  endtask

  initial begin
    rst = 1'b1; valid = 1'b1; last = 1'b0; in_data = 32'hFFFF_FFFF;
    cfg_we = 1'b0; cfg_mode = 4'b0000; cfg_merge = 1'b0; cnt_clr = 1'b0; s_clr = 1'b0;
    tick(); tick();

    // 1 Reset with a pending load
    chk_state("reset", 32'h0, 32'd0, 32'd0);
    chk("reset.en_vec", d_en_vec, 4'b1111);

    // 2 Full load, no merge
    rst = 1'b0; valid = 1'b1; last = 1'b1; in_data = 32'h4433_2211;
    #1 chk("load.en_vec", d_en_vec, 4'b1111);
    tick();
    chk_state("load", 32'h4433_2211, 32'd32, 32'd1);

    // Program mode=0001 during an idle cycle
    valid = 1'b0; last = 1'b1; cfg_we = 1'b1; cfg_mode = 4'b0001; cfg_merge = 1'b0;
    #1 chk("cfg1.en_vec", d_en_vec, 4'b0000);
    tick();
    cfg_we = 1'b0;

    // 3 Copy on idle, group 0 takes group 1's value
    valid = 1'b0; last = 1'b0;
    #1 chk("copy.en_vec", d_en_vec, 4'b0001);
    tick();
    chk_state("copy", 32'h4433_2222, 32'd40, 32'd2);

    // Reload and turn on merge in the same cycle (load uses old config)
    valid = 1'b1; last = 1'b1; in_data = 32'h4433_2211;
    cfg_we = 1'b1; cfg_mode = 4'b0001; cfg_merge = 1'b1;
    tick();
    cfg_we = 1'b0;
    chk_state("reload", 32'h4433_2211, 32'd72, 32'd3);

    // 4 Same copy with merge: identical contents, all enables set
    valid = 1'b0; last = 1'b0;
    #1 chk("merge.en_vec", d_en_vec, 4'b1111);
    tick();
    chk_state("merge", 32'h4433_2222, 32'd104, 32'd4);

    // 5 Idle in merge mode
    valid = 1'b0; last = 1'b1;
    #1 chk("idle.en_vec", d_en_vec, 4'b0000);
    tick();
    chk_state("idle", 32'h4433_2222, 32'd104, 32'd4);

    // All groups COPY, no merge: rotation through the chain
    cfg_we = 1'b1; cfg_mode = 4'b1111; cfg_merge = 1'b0;
    tick();
    cfg_we = 1'b0;
    valid = 1'b0; last = 1'b0;
    #1 chk("rot.en_vec", d_en_vec, 4'b1111);
    tick();
    chk_state("rot", 32'h2244_3322, 32'd136, 32'd5);

    // cfg write to all-HOLD in the same cycle: still rotates with old config
    cfg_we = 1'b1; cfg_mode = 4'b0000; cfg_merge = 1'b0;
    tick();
    cfg_we = 1'b0;
    chk_state("cfgold", 32'h2222_4433, 32'd168, 32'd6);
    #1 chk("cfgnew.en_vec", d_en_vec, 4'b0000);
    tick();
    chk_state("cfgnew", 32'h2222_4433, 32'd168, 32'd6);

    // cnt_clr beats a same-cycle increment
    valid = 1'b1; last = 1'b1; in_data = 32'h0F0E_0D0C; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_state("clr", 32'h0F0E_0D0C, 32'd0, 32'd0);
    in_data = 32'hA1B2_C3D4;
    tick();
    chk_state("postclr", 32'hA1B2_C3D4, 32'd32, 32'd1);

    // Reset mid-burst with a config write pending
    rst = 1'b1; valid = 1'b1; last = 1'b0; in_data = 32'h5555_AAAA;
    cfg_we = 1'b1; cfg_mode = 4'b1111; cfg_merge = 1'b1;
    tick();
    rst = 1'b0; cfg_we = 1'b0;
    chk_state("midrst", 32'h0, 32'd0, 32'd0);
    valid = 1'b0; last = 1'b0;
    #1 chk("midrst.en_vec", d_en_vec, 4'b0000);

    // Saturation on the 8-bit counter copy
    s_clr = 1'b1; valid = 1'b0; last = 1'b1;
    tick();
    s_clr = 1'b0;
    chk("sat.clr", s_bits, 8'd0);
    valid = 1'b1; in_data = 32'h0102_0304;
    for (int i = 0; i < 7; i++) tick();
    chk("sat.bits224", s_bits, 8'd224);
    tick();
    chk("sat.bits255", s_bits, 8'd255);
    tick();
    chk("sat.bitsheld", s_bits, 8'd255);
    chk("sat.cyc9", s_cycles, 8'd9);
    for (int i = 0; i < 250; i++) tick();
    chk("sat.cycles", s_cycles, 8'd255);
    chk("sat.out", s_out, 32'h0102_0304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
